// File: rtl/ifetch_stage.sv
// ifetch_stage: PC, ROM address and IF/ID register for the
// MIPS-subset pipeline, with stall, branch/jump redirect and flush.
//
// Parameters:
//   RESET_PC      PC loaded on reset (word-aligned)
// Inputs:
//   clk, reset    clock, synchronous active-high reset
//   stall         hold PC and IF/ID
//   branch_taken  redirect to branch_target (beats jump, stall)
//   branch_target branch destination byte address
//   jump          J-type in decode; redirect if IF/ID valid
//   jump_index    instr[25:0] of that jump
//   imem_data     combinational ROM read data
// Outputs:
//   imem_addr     ROM address (= PC)
//   if_id_instr   latched instruction (0 when not valid)
//   if_id_pc4     PC+4 of the latched instruction
//   if_id_valid   IF/ID holds a real instruction
//   misalign_err  sticky: a branch target was not word-aligned
//   fetch_count   instructions latched valid since reset
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] jump_addr;
  logic        do_jump;

  assign pc4       = pc + 32'd4;
  assign jump_addr = {if_id_pc4[31:28],
                      jump_index, 2'b00};
  // A jump is only real if the word in decode is.
  assign do_jump   = jump & if_id_valid;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      if_id_instr  <= 32'd0;
      if_id_pc4    <= 32'd0;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else if (branch_taken) begin
      pc          <= {branch_target[31:2], 2'b00};
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      if (branch_target[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end else if (do_jump) begin
      pc          <= jump_addr;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      // imem_data is only sampled here.
      pc          <= pc4;
      if_id_instr <= imem_data;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed vector bench for ifetch_stage.
// Two instances: RESET_PC=0 and RESET_PC=32'hFFFF_FFFC.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err;

  logic        reset1;
  logic [31:0] imem_addr1, imem_data1;
  logic [31:0] if_id_instr1, if_id_pc41, fetch_count1;
  logic        if_id_valid1, misalign_err1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2400_0000 ^ a;
  endfunction

  assign imem_data  = rom(imem_addr);
  assign imem_data1 = rom(imem_addr1);

  ifetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid),
    .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset1), .stall(1'b0),
    .branch_taken(1'b0),
    .branch_target(32'd0),
    .jump(1'b0), .jump_index(26'd0),
    .imem_addr(imem_addr1), .imem_data(imem_data1),
    .if_id_instr(if_id_instr1), .if_id_pc4(if_id_pc41),
    .if_id_valid(if_id_valid1),
    .misalign_err(misalign_err1),
    .fetch_count(fetch_count1)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] ji;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_v;
    logic        e_m;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic br,
    input logic [31:0] tgt, input logic jmp,
    input logic [25:0] ji, input logic [31:0] ea,
    input logic [31:0] ei, input logic [31:0] ep,
    input logic ev, input logic em,
    input logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
    v.jmp = jmp; v.ji = ji; v.e_addr = ea;
    v.e_instr = ei; v.e_pc4 = ep; v.e_v = ev;
    v.e_m = em; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // rst stl br tgt jmp ji | addr instr pc4 v m cnt
    tv[0]  = mk(1,0,0,0,0,0, 32'h00, 0,         32'h00,0,0,0);
    tv[1]  = mk(0,0,0,0,0,0, 32'h04, rom(32'h00),32'h04,1,0,1);
    tv[2]  = mk(0,0,0,0,0,0, 32'h08, rom(32'h04),32'h08,1,0,2);
    tv[3]  = mk(0,1,0,0,0,0, 32'h08, rom(32'h04),32'h08,1,0,2);
    tv[4]  = mk(0,1,0,0,0,0, 32'h08, rom(32'h04),32'h08,1,0,2);
    tv[5]  = mk(0,1,0,0,0,0, 32'h08, rom(32'h04),32'h08,1,0,2);
    tv[6]  = mk(0,0,0,0,0,0, 32'h0C, rom(32'h08),32'h0C,1,0,3);
    tv[7]  = mk(0,0,1,32'h14,0,0, 32'h14, 0,    32'h00,0,0,3);
    tv[8]  = mk(0,0,0,0,0,0, 32'h18, rom(32'h14),32'h18,1,0,4);
    tv[9]  = mk(0,0,0,0,1,3, 32'h0C, 0,         32'h00,0,0,4);
    tv[10] = mk(0,0,0,0,1,3, 32'h10, rom(32'h0C),32'h10,1,0,5);
    tv[11] = mk(0,0,1,32'h40,1,3, 32'h40, 0,    32'h00,0,0,5);
    tv[12] = mk(0,0,0,0,0,0, 32'h44, rom(32'h40),32'h44,1,0,6);
    tv[13] = mk(0,1,1,32'h60,0,0, 32'h60, 0,    32'h00,0,0,6);
    tv[14] = mk(0,0,0,0,0,0, 32'h64, rom(32'h60),32'h64,1,0,7);
    tv[15] = mk(0,0,1,32'h22,0,0, 32'h20, 0,    32'h00,0,1,7);
    tv[16] = mk(0,0,0,0,0,0, 32'h24, rom(32'h20),32'h24,1,1,8);
    tv[17] = mk(0,1,0,0,0,0, 32'h24, rom(32'h20),32'h24,1,1,8);
    tv[18] = mk(1,1,1,32'h80,1,3, 32'h00, 0,    32'h00,0,0,0);
    tv[19] = mk(0,0,0,0,0,0, 32'h04, rom(32'h00),32'h04,1,0,1);

    reset1 = 1'b1;
    for (int i = 0; i < NV; i++) begin
      reset         = tv[i].rst;
      stall         = tv[i].stl;
      branch_taken  = tv[i].br;
      branch_target = tv[i].tgt;
      jump          = tv[i].jmp;
      jump_index    = tv[i].ji;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr", i),
          imem_addr, tv[i].e_addr);
      chk($sformatf("v%0d instr", i),
          if_id_instr, tv[i].e_instr);
      chk($sformatf("v%0d pc4", i),
          if_id_pc4, tv[i].e_pc4);
      chk($sformatf("v%0d valid", i),
          {31'd0, if_id_valid}, {31'd0, tv[i].e_v});
      chk($sformatf("v%0d misalign", i),
          {31'd0, misalign_err}, {31'd0, tv[i].e_m});
      chk($sformatf("v%0d count", i),
          fetch_count, tv[i].e_cnt);
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    jump = 1'b0;

    // PC wrap from 32'hFFFF_FFFC, then a mid-stream reset.
    reset1 = 1'b1;
    @(posedge clk); #1;
    chk("w reset addr", imem_addr1, 32'hFFFF_FFFC);
    chk("w reset valid", {31'd0, if_id_valid1}, 32'd0);
    reset1 = 1'b0;
    @(posedge clk); #1;
    chk("w1 instr", if_id_instr1, rom(32'hFFFF_FFFC));
    chk("w1 pc4", if_id_pc41, 32'h0);
    chk("w1 addr", imem_addr1, 32'h0);
    @(posedge clk); #1;
    chk("w2 instr", if_id_instr1, rom(32'h0));
    chk("w2 pc4", if_id_pc41, 32'h4);
    chk("w2 count", fetch_count1, 32'd2);
    @(posedge clk); #1;
    chk("w3 addr", imem_addr1, 32'h8);
    reset1 = 1'b1;
    @(posedge clk); #1;
    reset1 = 1'b0;
    chk("wr addr", imem_addr1, 32'hFFFF_FFFC);
    chk("wr instr", if_id_instr1, 32'h0);
    chk("wr pc4", if_id_pc41, 32'h0);
    chk("wr valid", {31'd0, if_id_valid1}, 32'd0);
    chk("wr misalign", {31'd0, misalign_err1}, 32'd0);
    chk("wr count", fetch_count1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the pipelined MIPS-subset processor. Holds the program counter, drives the instruction ROM address, and captures the returned instruction word into the IF/ID pipeline register. It also handles stall, branch and jump redirects with flush, and keeps a count of fetched instructions. It sits directly upstream of the instruction ROM and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; holds the PC and the IF/ID register.
- branch_taken  in  1  branch resolved taken (EX stage); redirect to branch_target.
- branch_target  in  32  byte address of the branch destination.
- jump  in  1  J-type instruction is in decode; redirect to the jump target.
- jump_index  in  26  instr[25:0] of the jump currently in IF/ID.
- imem_addr  out  32  ROM address; combinationally equal to the PC register.
- imem_data  in  32  ROM read data; combinational response to imem_addr.
- if_id_instr  out  32  latched instruction; 32'h0000_0000 (NOP) when not valid.
- if_id_pc4  out  32  PC+4 of the latched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  number of instructions latched with valid=1 since reset.

## Operation
- Registers: pc, if_id_instr, if_id_pc4, if_id_valid, misalign_err, fetch_count.
- pc4 = pc + 32'd4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- jump_addr = {if_id_pc4[31:28], jump_index, 2'b00}.
- Per-edge priority, highest first:
  1. reset: pc<=RESET_PC, if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0, misalign_err<=0, fetch_count<=0.
  2. branch_taken: pc<={branch_target[31:2],2'b00}; IF/ID flushed (instr 0, valid 0, pc4 0). misalign_err is set if branch_target[1:0]!=0.
  3. jump: pc<=jump_addr; IF/ID flushed. Applied only if if_id_valid=1; otherwise jump is ignored.
  4. stall: pc and all IF/ID fields hold.
  5. Otherwise (sequential): pc<=pc4, if_id_instr<=imem_data, if_id_pc4<=pc4, if_id_valid<=1, fetch_count<=fetch_count+1.
- Redirect overrides stall. The branch in EX is older than the stalled instruction in decode, so the stalled instruction is discarded.
- branch_taken and jump in the same cycle: the branch wins and the jump is discarded.
- fetch_count increments only in case 5. It wraps at 2^32.
- imem_data is sampled only in case 5. X on imem_data in other cycles must not reach the outputs.

## Timing
- Reset values: imem_addr=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, misalign_err=0, fetch_count=0.
- Fetch latency is 1 cycle. The word at address A appears on if_id_instr at the edge after imem_addr=A, provided there is no stall or redirect at that edge.
- Redirect penalty:
  - A branch costs 1 bubble cycle from this stage (valid=0); the target instruction is valid 2 edges after branch_taken is sampled.
  - A jump costs 1 bubble cycle.
- Stall can be held for any number of cycles. When stall is released, fetching resumes at the held PC with no lost or duplicated instruction.
- Reset asserted mid-operation takes effect at the next edge regardless of stall or redirect. Pending redirects are lost.

## Test plan
- Reset then free-run with ROM words W0..W3 at 0x0..0xC:
  - after reset, imem_addr=0;
  - successive edges give if_id_instr=W0,W1,W2 with if_id_pc4=4,8,12;
  - fetch_count=3.
- Stall asserted for 3 cycles while if_id_instr=W1: imem_addr holds 0x8, IF/ID holds W1, fetch_count holds. After release, the next edge latches W2.
- branch_taken=1 with branch_target=0x14:
  - next edge: imem_addr=0x14, if_id_valid=0, if_id_instr=0;
  - following edge: if_id_instr=word@0x14.
- Jump with if_id_pc4=0x18, jump_index=26'd3: next edge imem_addr=0x0000_000C and IF/ID is flushed. Repeat with if_id_valid=0: no redirect occurs.
- Simultaneous cases:
  - branch_taken and jump together: target is branch_target;
  - branch_taken with stall: redirect still occurs;
  - branch_target=0x22: pc=0x20 and misalign_err=1, and the flag stays 1 until reset.
- RESET_PC=32'hFFFF_FFFC: the second fetch is at address 0 with if_id_pc4=0. A reset pulse mid-stream returns imem_addr to RESET_PC and clears all outputs within 1 edge.
